dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, meaning data memory size in bytes (multiple of 8).
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles spent in BUSY per request (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  CPU presents a memory request.
REQ-006 SHALL have port req_ready  output  1  responder accepts a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = write (rmmovq/pushq/call), 0 = read (mrmovq/popq/ret).
REQ-008 SHALL have port req_addr  input  64  byte address of the 8-byte access.
REQ-009 SHALL have port req_wdata  input  64  write data.
REQ-010 SHALL have port rsp_valid  output  1  response available.
REQ-011 SHALL have port rsp_ready  input  1  CPU consumes the response.
REQ-012 SHALL have port rsp_rdata  output  64  read data (valM).
REQ-013 SHALL have port rsp_error  output  1  address fault (dmem_error).

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, RESP; req_ready=1 only in IDLE, rsp_valid=1 only in RESP.
REQ-015 SHALL accept a request when req_valid & req_ready at a rising edge, registering req_write, req_addr, req_wdata and loading a down-counter with LATENCY-1; state -> BUSY.
REQ-016 SHALL ignore req_* inputs outside IDLE; registered copies are the only values used.
REQ-017 SHALL decrement the counter each BUSY cycle and move BUSY -> RESP on the edge where counter is 0; accept-to-rsp_valid latency is exactly LATENCY+1 edges... measured as rsp_valid rising LATENCY cycles after the accept edge.
REQ-018 SHALL commit the access on the BUSY -> RESP edge: write stores wdata, read captures data into rsp_rdata.
REQ-019 SHALL use little-endian byte order: byte addr+k holds bits [8k+7:8k], k=0..7; unaligned addresses legal.
REQ-020 SHALL flag error when addr + 8 > MEM_BYTES, computed at 65-bit width so addresses near 2^64 do not wrap into range.
REQ-021 SHALL, on error, suppress any write, drive rsp_rdata=0 and rsp_error=1.
REQ-022 SHALL drive rsp_rdata=0 for write responses; rsp_error per REQ-020.
REQ-023 SHALL hold rsp_valid, rsp_rdata, rsp_error stable in RESP until rsp_valid & rsp_ready; then state -> IDLE, outputs -> 0.
REQ-024 SHALL not accept a new request in the cycle a response is consumed (earliest next accept is the following edge).
REQ-025 SHALL make a read following a write to an overlapping address return the newly written bytes.

Reset
REQ-026 SHALL, while rst_n=0, force state IDLE, counter 0, req_ready=1 after release, rsp_valid=0, rsp_rdata=0, rsp_error=0, independent of clk.
REQ-027 SHALL abandon any in-flight request on reset; a write not yet committed SHALL NOT modify memory.
REQ-028 SHALL NOT clear memory contents on reset; contents survive reset.

Verification
REQ-029 Write 0x1122334455667788 to addr 0x100, consume, then read 0x100 -> rsp_rdata=0x1122334455667788, rsp_error=0; rsp_valid rises exactly LATENCY cycles after each accept.
REQ-030 After REQ-029 data, read addr 0x101 -> rsp_rdata=0x??11223344556677 with upper byte = memory byte 0x108 (bench prewrites 0x108 byte 0xAB -> 0xAB11223344556677).
REQ-031 Read addr 1017 (MEM_BYTES=1024) -> rsp_error=1, rsp_rdata=0; write addr 0xFFFFFFFFFFFFFFFC -> rsp_error=1, no memory byte changed; addr 1016 -> error=0.
REQ-032 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable; req_valid asserted meanwhile -> req_ready=0, no second accept.
REQ-033 Assert rst_n=0 mid-BUSY of a write of 0xDEAD to 0x200 (prior content 0x0) -> rsp_valid=0 immediately, later read of 0x200 returns 0x0.
REQ-034 Back-to-back: req_valid held high with rsp_ready=1 -> accepts spaced LATENCY+2 cycles apart, each response correct.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for a pipelined CPU: valid/ready request in, fixed-latency
// little-endian 8-byte access, valid/ready response out with address-fault flag.
module dmem_responder #(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_error
);
    localparam int unsigned AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q;
    logic [63:0] addr_q, wdata_q;
    logic [63:0] rdata_q, rdata_d;
    logic        error_q, error_d;
    logic        accept, commit, addr_err;
    logic [63:0] mem_rdata;

    logic [7:0] mem [MEM_BYTES];

    assign accept = (state_q == StIdle) && req_valid;
    assign commit = (state_q == StBusy) && (cnt_q == 4'd0);

    // 65-bit compare so addresses near 2^64 cannot wrap back into range
    assign addr_err = ({1'b0, addr_q} + 65'd8) > 65'(MEM_BYTES);

    always_comb begin
        mem_rdata = '0;
        for (int k = 0; k < 8; k++) begin
            mem_rdata[8*k +: 8] = mem[addr_q[AW-1:0] + AW'(k)];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        error_d = error_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = StBusy;
                    cnt_d   = 4'(LATENCY - 1);
                end
            end
            StBusy: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                    error_d = addr_err;
                    rdata_d = (write_q || addr_err) ? 64'd0 : mem_rdata;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                    rdata_d = 64'd0;
                    error_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rdata_q <= 64'd0;
            error_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
            if (accept) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    // Memory has no reset: contents survive rst_n, and reset idles the FSM so
    // an uncommitted write never lands.
    always_ff @(posedge clk) begin
        if (commit && write_q && !addr_err) begin
            for (int k = 0; k < 8; k++) begin
                mem[addr_q[AW-1:0] + AW'(k)] <= wdata_q[8*k +: 8];
            end
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_error = error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table of full transactions plus
// hand sequences for stall, reset-mid-busy and back-to-back streaming.
module tb_dmem_responder;
    localparam int unsigned MEM_BYTES = 1024;
    localparam int unsigned LATENCY   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [63:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_error;
    logic [63:0] rsp_rdata;

    int ntests = 0;
    int nfail  = 0;

    dmem_responder #(
        .MEM_BYTES(MEM_BYTES),
        .LATENCY  (LATENCY)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the response is consumed.
    task automatic txn(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                       output logic [63:0] rdata, output logic err, output int lat);
        int guard;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = rsp_rdata;
        err   = rsp_error;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[$];
        logic [63:0] rd;
        logic        er;
        int          lat;
        logic [63:0] b2b_addr[3];
        logic [63:0] b2b_exp[3];
        int          acc[3];
        int          n, m;

        vecs.push_back('{"wr_100",     1'b1, 64'h100, 64'h1122334455667788, 64'h0, 1'b0});
        vecs.push_back('{"wr_108",     1'b1, 64'h108, 64'h00000000000000AB, 64'h0, 1'b0});
        vecs.push_back('{"rd_100",     1'b0, 64'h100, 64'h0, 64'h1122334455667788, 1'b0});
        vecs.push_back('{"rd_101",     1'b0, 64'h101, 64'h0, 64'hAB11223344556677, 1'b0});
        vecs.push_back('{"wr_1016",    1'b1, 64'd1016, 64'hCAFEF00D12345678, 64'h0, 1'b0});
        vecs.push_back('{"rd_1017",    1'b0, 64'd1017, 64'h0, 64'h0, 1'b1});
        vecs.push_back('{"wr_top",     1'b1, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1});
        vecs.push_back('{"rd_wrap",    1'b0, 64'hFFFFFFFFFFFFFFF8, 64'h0, 64'h0, 1'b1});
        vecs.push_back('{"rd_1016",    1'b0, 64'd1016, 64'h0, 64'hCAFEF00D12345678, 1'b0});
        vecs.push_back('{"wr_200",     1'b1, 64'h200, 64'h0, 64'h0, 1'b0});
        vecs.push_back('{"wr_104",     1'b1, 64'h104, 64'hDDCCBBAA99887766, 64'h0, 1'b0});
        vecs.push_back('{"rd_100_ovl", 1'b0, 64'h100, 64'h0, 64'h9988776655667788, 1'b0});

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 64'h0;
        req_wdata = 64'h0;
        rsp_ready = 1'b0;

        #3;
        check("reset_rsp_valid", 64'(rsp_valid), 64'h0);
        check("reset_rsp_rdata", rsp_rdata, 64'h0);
        check("reset_rsp_error", 64'(rsp_error), 64'h0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        check("reset_req_ready", 64'(req_ready), 64'h1);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            check({vecs[i].name, "_latency"}, 64'(lat), 64'(LATENCY));
            check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
            check({vecs[i].name, "_error"}, 64'(er), 64'(vecs[i].exp_err));
            check({vecs[i].name, "_cleared"}, {rsp_rdata[62:0], rsp_valid}, 64'h0);
        end

        // Stall in RESP with a competing request pending
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h100;
        @(posedge clk); #1;
        req_addr = 64'd1016;
        for (int c = 0; c < LATENCY; c++) begin
            @(posedge clk); #1;
        end
        check("stall_enter_valid", 64'(rsp_valid), 64'h1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("stall_valid", 64'(rsp_valid), 64'h1);
            check("stall_rdata", rsp_rdata, 64'h9988776655667788);
            check("stall_req_ready", 64'(req_ready), 64'h0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("consume_req_ready", 64'(req_ready), 64'h1);
        check("consume_rsp_valid", 64'(rsp_valid), 64'h0);
        req_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("no_second_accept", 64'(rsp_valid), 64'h0);
        end

        // Reset in the middle of BUSY for a write to 0x200
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h200; req_wdata = 64'hDEAD;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("midbusy_req_ready", 64'(req_ready), 64'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midbusy_rst_valid", 64'(rsp_valid), 64'h0);
        check("midbusy_rst_ready", 64'(req_ready), 64'h1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        txn(1'b0, 64'h200, 64'h0, rd, er, lat);
        check("rd_200_after_rst", rd, 64'h0);
        check("rd_200_after_rst_err", 64'(er), 64'h0);
        txn(1'b0, 64'd1016, 64'h0, rd, er, lat);
        check("rd_1016_survives_rst", rd, 64'hCAFEF00D12345678);

        // Back-to-back reads with req_valid and rsp_ready held high
        b2b_addr[0] = 64'h100; b2b_exp[0] = 64'h9988776655667788;
        b2b_addr[1] = 64'd1016; b2b_exp[1] = 64'hCAFEF00D12345678;
        b2b_addr[2] = 64'h200; b2b_exp[2] = 64'h0;
        n = 0; m = 0;
        req_write = 1'b0; req_addr = b2b_addr[0]; req_valid = 1'b1; rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && m < 3; cyc++) begin
            if (rsp_valid) begin
                check("b2b_rdata", rsp_rdata, b2b_exp[m]);
                m++;
            end
            if (req_ready && req_valid && n < 3) begin
                acc[n] = cyc;
                n++;
            end
            @(posedge clk); #1;
            if (n < 3) req_addr = b2b_addr[n];
            else req_valid = 1'b0;
        end
        req_valid = 1'b0; rsp_ready = 1'b0;
        check("b2b_responses", 64'(m), 64'd3);
        check("b2b_accepts", 64'(n), 64'd3);
        if (n == 3) begin
            check("b2b_spacing_0", 64'(acc[1] - acc[0]), 64'(LATENCY + 2));
            check("b2b_spacing_1", 64'(acc[2] - acc[1]), 64'(LATENCY + 2));
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
